// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op-code constants and FSM state encoding for multicycle_alu
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b1001;
  localparam logic [3:0] OP_SRL  = 4'b1010;
  localparam logic [3:0] OP_SRA  = 4'b1011;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_MUL  = 4'b1101;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_BUSY = 2'd1,
    ST_DONE     = 2'd2
  } state_e;

endpackage

// File: rtl/alu_seq_mul.sv
// rtl/alu_seq_mul.sv - unsigned shift-add multiplier, one multiplier bit per cycle
module alu_seq_mul #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;

  // lo_q starts as the multiplier and fills with product bits as it shifts out
  always_comb begin
    sum        = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
    step_hi    = sum[WIDTH:1];
    step_lo    = {sum[0], lo_q[WIDTH-1:1]};
    done       = busy_q && (cnt_q == LAST);
    product_hi = step_hi;
    product_lo = step_lo;

    busy_d  = busy_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (start) begin
      busy_d  = 1'b1;
      cnt_d   = '0;
      mcand_d = a;
      hi_d    = '0;
      lo_d    = b;
    end else if (busy_q) begin
      hi_d  = step_hi;
      lo_d  = step_lo;
      cnt_d = cnt_q + 1'b1;
      if (done) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: rtl/multicycle_alu.sv
// rtl/multicycle_alu.sv - valid/ready ALU: single-cycle ops plus iterative unsigned MUL
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             cout,
  output logic             overflow,
  output logic             illegal
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] result_hi_q, result_hi_d;
  logic             zero_q, zero_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             ill_q, ill_d;

  logic             accept, is_mul, is_sub;
  logic [WIDTH-1:0] b_add;
  logic [WIDTH:0]   sum_ext;
  logic             add_cout, add_ovf;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_cout, alu_ovf, alu_ill;
  logic             mul_done;
  logic [WIDTH-1:0] mul_hi, mul_lo;

  assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign out_valid = (state_q == ST_DONE);
  assign accept    = in_valid && in_ready;
  assign is_mul    = (op == OP_MUL);

  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk        (CLK),
    .rst_n      (RST_N),
    .start      (accept && is_mul),
    .a          (A),
    .b          (B),
    .done       (mul_done),
    .product_hi (mul_hi),
    .product_lo (mul_lo)
  );

  // SUB, SLT and SLTU all share the A + ~B + 1 datapath
  always_comb begin
    is_sub   = (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU);
    b_add    = is_sub ? ~B : B;
    sum_ext  = {1'b0, A} + {1'b0, b_add} + {{WIDTH{1'b0}}, is_sub};
    add_cout = sum_ext[WIDTH];
    add_ovf  = (A[WIDTH-1] ^ b_add[WIDTH-1] ^ sum_ext[WIDTH-1]) ^ add_cout;
    shamt    = B[SHAMT_W-1:0];

    alu_res  = '0;
    alu_cout = 1'b0;
    alu_ovf  = 1'b0;
    alu_ill  = 1'b0;
    case (op)
      OP_AND: alu_res = A & B;
      OP_OR:  alu_res = A | B;
      OP_XOR: alu_res = A ^ B;
      OP_NOR: alu_res = ~(A | B);
      OP_ADD, OP_SUB: begin
        alu_res  = sum_ext[WIDTH-1:0];
        alu_cout = add_cout;
        alu_ovf  = add_ovf;
      end
      OP_SLT: begin
        alu_res[0] = add_ovf ^ sum_ext[WIDTH-1];
        alu_cout   = add_cout;
        alu_ovf    = add_ovf;
      end
      OP_SLTU: begin
        alu_res[0] = ~add_cout;
        alu_cout   = add_cout;
        alu_ovf    = add_ovf;
      end
      OP_SLL: alu_res = A << shamt;
      OP_SRL: alu_res = A >> shamt;
      OP_SRA: alu_res = $unsigned($signed(A) >>> shamt);
      OP_MUL: alu_res = '0;
      default: alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    zero_d      = zero_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    ill_d       = ill_q;

    if (accept) begin
      state_d = is_mul ? ST_MUL_BUSY : ST_DONE;
    end else begin
      case (state_q)
        ST_MUL_BUSY: if (mul_done) state_d = ST_DONE;
        ST_DONE:     if (out_ready) state_d = ST_IDLE;
        default:     state_d = state_q;
      endcase
    end

    // result registers only change when a new result lands, so they hold while stalled
    if (accept && !is_mul) begin
      result_d    = alu_res;
      result_hi_d = '0;
      zero_d      = (alu_res == '0);
      cout_d      = alu_cout;
      ovf_d       = alu_ovf;
      ill_d       = alu_ill;
    end else if (mul_done) begin
      result_d    = mul_lo;
      result_hi_d = mul_hi;
      zero_d      = (mul_lo == '0);
      cout_d      = 1'b0;
      ovf_d       = 1'b0;
      ill_d       = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      result_q    <= '0;
      result_hi_q <= '0;
      zero_q      <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      ill_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      zero_q      <= zero_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      ill_q       <= ill_d;
    end
  end

  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign zero      = zero_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;
  assign illegal   = ill_q;

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width (legal 8..64).
REQ-002 SHALL have parameter SHAMT_W, default $clog2(WIDTH), meaning shift-amount bits taken from B[SHAMT_W-1:0].
REQ-003 SHALL have port CLK  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operation request.
REQ-006 SHALL have port in_ready  output  1  unit can accept a request this cycle.
REQ-007 SHALL have ports A, B  input  WIDTH  operands.
REQ-008 SHALL have port op  input  4  operation code.
REQ-009 SHALL have port out_valid  output  1  result registers hold a completed result.
REQ-010 SHALL have port out_ready  input  1  consumer takes the result this cycle.
REQ-011 SHALL have port result  output  WIDTH  low result word.
REQ-012 SHALL have port result_hi  output  WIDTH  MUL upper product word; 0 for other ops.
REQ-013 SHALL have ports zero, cout, overflow, illegal  output  1 each  status flags registered with result.

Function
REQ-014 SHALL accept a request when in_valid && in_ready, capturing A, B, op.
REQ-015 SHALL decode op: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0110 SUB, 0111 SLT, 1000 SLTU, 1001 SLL, 1010 SRL, 1011 SRA, 1100 NOR, 1101 MUL (unsigned).
REQ-016 SHALL complete all non-MUL ops with out_valid asserted on the edge following acceptance (latency 1).
REQ-017 SHALL compute SUB/SLT as A + ~B + 1; cout = carry out of bit WIDTH-1; overflow = carry into MSB XOR carry out of MSB; SLT result = overflow XOR sum MSB, zero-extended.
REQ-018 SHALL compute SLTU result = ~cout of A + ~B + 1, zero-extended.
REQ-019 SHALL drive cout and overflow as 0 for ops other than ADD, SUB, SLT, SLTU.
REQ-020 SHALL drive zero = (result == 0) for every op, including MUL (low word only).
REQ-021 SHALL implement MUL as iterative shift-add, one multiplier bit per cycle: out_valid rises exactly WIDTH+1 edges after acceptance; {result_hi,result} = A*B, 2*WIDTH bits.
REQ-022 SHALL use states IDLE, MUL_BUSY, DONE: IDLE->DONE on non-MUL accept; IDLE->MUL_BUSY on MUL accept; MUL_BUSY->DONE when bit counter reaches WIDTH-1; DONE->IDLE on out_ready with no new accept; DONE->DONE or DONE->MUL_BUSY on out_ready with simultaneous accept.
REQ-023 SHALL drive in_ready = (state==IDLE) || (state==DONE && out_ready); in_ready = 0 throughout MUL_BUSY.
REQ-024 SHALL hold result, result_hi and all flags stable while out_valid && !out_ready.
REQ-025 SHALL, for undefined op codes, complete with latency 1, result = 0, result_hi = 0, illegal = 1; illegal = 0 for defined ops.
REQ-026 SHALL ignore in_valid when in_ready = 0 (no capture, no state change).
REQ-027 SHALL use only B[SHAMT_W-1:0] for shifts; shift by 0 returns A.

Reset
REQ-028 SHALL, on RST_N low, immediately force state IDLE, out_valid 0, result 0, result_hi 0, zero/cout/overflow/illegal 0, MUL counter 0.
REQ-029 SHALL abandon any in-progress MUL on reset without producing a result.
REQ-030 SHALL assert in_ready on the first edge after RST_N deasserts.

Structure
REQ-031 SHALL place op-code constants and state encodings in shared package alu_pkg.
REQ-032 SHALL place the iterative multiplier in sub-module alu_seq_mul (WIDTH parameter, start/done handshake); all other ops stay in the top level.

Verification
REQ-033 SHALL cover: WIDTH=32, ADD A=0x7FFFFFFF B=1 -> 1 cycle later result 0x80000000, overflow 1, cout 0.
REQ-034 SHALL cover: SUB A=5 B=5 -> result 0, zero 1, cout 1; SLT A=0xFFFFFFFF B=1 -> result 1; SLTU same operands -> result 0.
REQ-035 SHALL cover: MUL A=0xFFFFFFFF B=0xFFFFFFFF -> out_valid after 33 edges, result_hi 0xFFFFFFFE, result 0x00000001; in_ready 0 throughout.
REQ-036 SHALL cover: out_ready held 0 for 5 cycles after an AND result -> result, flags and out_valid unchanged, in_ready 0; back-to-back accept on out_ready edge -> next result 1 cycle later.
REQ-037 SHALL cover: RST_N pulsed low mid-MUL (cycle 10) -> out_valid 0 immediately, no result afterwards; op=1111 -> illegal 1, result 0.
REQ-038 SHALL cover: WIDTH=8 SRA A=0x80 B=0x03 -> result 0xF0; SLL with B=0x09 -> shift by 1 -> result 0x00.
